uart_tx_ctrl: RTL

//  Transmit sequencer for the UART: pops bytes from the TX FIFO, frames them per the line-control

---
 rtl/uart_pkg.sv | 57 +++++
 rtl/uart_baud_gen.sv | 61 ++++++
 rtl/uart_tx_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : state encodings, word-length/oversampling constants and parity  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } uart_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam logic [4:0] OS_16 = 5'd16;
    localparam logic [4:0] OS_13 = 5'd13;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] wls;
        logic       stb;
        logic       pen;
        logic       par;
    } uart_frame_t;

    function automatic logic [7:0] uart_word_mask(input logic [1:0] wls);
        logic [7:0] mask;
        case (wls)
            WLS_5:   mask = 8'h1F;
            WLS_6:   mask = 8'h3F;
            WLS_7:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Even parity makes the total count of ones (data + parity) even.
    function automatic logic uart_parity(input logic [7:0] data, input logic [1:0] wls,
                                         input logic eps, input logic sp);
        logic [7:0] masked;
        masked = data & uart_word_mask(wls);
        if (sp)
            return ~eps;
        else if (eps)
            return ^masked;
        else
            return ~^masked;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_baud_gen : divisor prescaler plus oversampling counter -> bit timing  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DLR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DLR_WIDTH-1:0] dlr,
    input  logic                 osm,
    input  logic                 clr,
    input  logic                 half_sel,
    output logic                 sample_tick,
    output logic                 bit_done
);

    localparam logic [DLR_WIDTH-1:0] DLR_ONE = {{(DLR_WIDTH-1){1'b0}}, 1'b1};

    logic [DLR_WIDTH-1:0] presc_q, presc_d;
    logic [3:0]           samp_q, samp_d;
    logic [4:0]           os_full;
    logic [4:0]           os_last;
    logic                 run;

    always_comb begin
        run         = (dlr != '0);
        os_full     = osm ? OS_13 : OS_16;
        os_last     = (half_sel ? (os_full >> 1) : os_full) - 5'd1;
        // >= keeps the prescaler from running away if dlr shrinks mid-count
        sample_tick = run && (presc_q >= (dlr - DLR_ONE));
        bit_done    = sample_tick && ({1'b0, samp_q} == os_last);

        presc_d = presc_q;
        samp_d  = samp_q;
        if (clr) begin
            presc_d = '0;
            samp_d  = '0;
        end else if (sample_tick) begin
            presc_d = '0;
            samp_d  = bit_done ? 4'd0 : samp_q + 4'd1;
        end else if (run) begin
            presc_d = presc_q + DLR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            samp_q  <= '0;
        end else begin
            presc_q <= presc_d;
            samp_q  <= samp_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_ctrl : pops TX FIFO bytes, frames them and drives TXD              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DLR_WIDTH = 16
) (
    input  logic                 apb_clk_in,
    input  logic                 apb_rstn_in,
    input  logic                 utrst_in,
    input  logic [DLR_WIDTH-1:0] dlr_in,
    input  logic                 osm_in,
    input  logic [1:0]           wls_in,
    input  logic                 stb_in,
    input  logic                 pen_in,
    input  logic                 eps_in,
    input  logic                 sp_in,
    input  logic                 bc_in,
    input  logic [7:0]           txf_data_in,
    input  logic                 txf_empty_in,
    output logic                 txf_pop_out,
    output logic                 txd_out,
    output logic                 busy_out,
    output logic                 temt_out
);

    uart_state_e state_q, state_d;
    uart_frame_t frame_q, frame_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop2_q, stop2_d;
    logic        pop_q, pop_d;
    logic        txd_q, txd_d;

    logic        pop_ok;
    logic        baud_clr;
    logic        half_sel;
    logic        baud_tick;
    logic        baud_done;
    logic        bit_end;
    logic [2:0]  last_bit;

    uart_baud_gen #(
        .DLR_WIDTH (DLR_WIDTH)
    ) u_baud (
        .clk         (apb_clk_in),
        .rst_n       (apb_rstn_in),
        .dlr         (dlr_in),
        .osm         (osm_in),
        .clr         (baud_clr),
        .half_sel    (half_sel),
        .sample_tick (baud_tick),
        .bit_done    (baud_done)
    );

    assign bit_end  = baud_done & baud_tick;
    assign last_bit = {1'b0, frame_q.wls} + 3'd4;
    // Second stop bit is a half bit only for 5-bit words.
    assign half_sel = (state_q == ST_STOP) & stop2_q & (frame_q.wls == WLS_5);
    assign pop_ok   = utrst_in & ~txf_empty_in & (dlr_in != '0) & ~pop_q;
    assign baud_clr = ~utrst_in | (state_q == ST_IDLE) | (state_d != state_q);

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        stop2_d   = stop2_q;
        pop_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pop_q)
                    state_d = ST_START;
                else if (pop_ok)
                    pop_d = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == last_bit) begin
                        state_d = frame_q.pen ? ST_PARITY : ST_STOP;
                        stop2_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    stop2_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (frame_q.stb && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        stop2_d = 1'b0;
                        pop_d   = pop_ok;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!utrst_in) begin
            state_d   = ST_IDLE;
            bit_idx_d = 3'd0;
            stop2_d   = 1'b0;
            pop_d     = 1'b0;
        end

        // Frame shadow is loaded on the pop edge so later config writes cannot disturb it.
        if (pop_d) begin
            frame_d.data = txf_data_in;
            frame_d.wls  = wls_in;
            frame_d.stb  = stb_in;
            frame_d.pen  = pen_in;
            frame_d.par  = uart_parity(txf_data_in, wls_in, eps_in, sp_in);
        end

        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = frame_d.data[bit_idx_d];
            ST_PARITY: txd_d = frame_d.par;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            bit_idx_q <= 3'd0;
            stop2_q   <= 1'b0;
            pop_q     <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            stop2_q   <= stop2_d;
            pop_q     <= pop_d;
            txd_q     <= txd_d;
        end
    end

    assign txf_pop_out = pop_q;
    assign txd_out     = txd_q & ~bc_in;
    assign busy_out    = (state_q != ST_IDLE);
    assign temt_out    = (state_q == ST_IDLE) & txf_empty_in;

endmodule
`default_nettype wire
